// File: rtl/xor_arb_pkg.sv
// Shared types and helpers for the xor_gate sharing arbiter.
package xor_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   // Index width with a floor of one bit so single-value ranges still get a port.
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/xor_arb_pick.sv
// Combinational one-hot picker: first valid requester at or after i_start, wrapping.
module xor_arb_pick
   import xor_arb_pkg::*;
#(
   parameter int  NREQ = 4,
   localparam int ID_W = id_width(NREQ)
)(
   input  logic [NREQ-1:0] i_valid,
   input  logic [ID_W-1:0] i_start,
   output logic [NREQ-1:0] o_grant,
   output logic [ID_W-1:0] o_idx
);

   logic w_found;

   // Rotating priority search; the first hit blocks all later candidates.
   always_comb begin
      int v_k;
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      v_k     = 0;
      for (int i = 0; i < NREQ; i++) begin
         v_k = (int'(i_start) + i) % NREQ;
         if (!w_found && i_valid[v_k]) begin
            o_grant[v_k] = 1'b1;
            o_idx        = ID_W'(v_k);
            w_found      = 1'b1;
         end else begin
            o_grant[v_k] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/xor_share_arbiter.sv
// Shares one external registered xor_gate among NREQ requesters, one transaction at a time.
// Define XOR_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module xor_share_arbiter
   import xor_arb_pkg::*;
#(
   parameter int  NREQ   = 4,
   parameter int  W      = 1,
   parameter int  XG_LAT = 1,
   localparam int ID_W   = id_width(NREQ)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic [W-1:0]        xg_a,
   output logic [W-1:0]        xg_b,
   input  logic [W-1:0]        xg_z,
   output logic                resp_valid,
   output logic [ID_W-1:0]     resp_id,
   output logic [W-1:0]        resp_z,
   input  logic                resp_ready
);

   localparam int CNT_W = id_width(XG_LAT);

   arb_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [NREQ-1:0]   w_grant;
   logic [ID_W-1:0]   w_gidx;
   logic [ID_W-1:0]   w_start;

`ifdef XOR_ARB_RR_EN
   logic [ID_W-1:0]   r_ptr;

   // Round-robin pointer moves just past each winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (r_state == IDLE && |req_valid) begin
         r_ptr <= (w_gidx == ID_W'(NREQ - 1)) ? '0 : w_gidx + ID_W'(1);
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign w_start = r_ptr;
`else
   assign w_start = '0;
`endif

   xor_arb_pick #(.NREQ(NREQ)) u_pick (
      .i_valid (req_valid),
      .i_start (w_start),
      .o_grant (w_grant),
      .o_idx   (w_gidx)
   );

   // Grant is only visible while idle, so at most one request is accepted per transaction.
   always_comb begin
      if (r_state == IDLE) begin
         req_ready = w_grant;
      end else begin
         req_ready = '0;
      end
   end

   // Transaction sequencer: latch operands, let the xor_gate sample, wait out its latency, hand off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         xg_a       <= '0;
         xg_b       <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_z     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req_valid) begin
                  xg_a    <= req_a[int'(w_gidx)*W +: W];
                  xg_b    <= req_b[int'(w_gidx)*W +: W];
                  resp_id <= w_gidx;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt   <= CNT_W'(XG_LAT - 1);
               r_state <= WAIT;
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  resp_z     <= xg_z;
                  resp_valid <= 1'b1;
                  r_state    <= RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed self-checking bench for xor_share_arbiter with a behavioural one-cycle xor_gate.
module tb_xor_share_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_valid;
   logic [3:0] req_a;
   logic [3:0] req_b;
   logic [3:0] req_ready;
   logic [0:0] xg_a;
   logic [0:0] xg_b;
   logic [0:0] xg_z;
   logic       resp_valid;
   logic [1:0] resp_id;
   logic [0:0] resp_z;
   logic       resp_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) xg_z <= xg_a ^ xg_b;

   xor_share_arbiter #(.NREQ(4), .W(1), .XG_LAT(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .xg_a       (xg_a),
      .xg_b       (xg_b),
      .xg_z       (xg_z),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_z     (resp_z),
      .resp_ready (resp_ready)
   );

   task automatic apply_reset;
      rst        = 1'b1;
      req_valid  = 4'b0000;
      req_a      = 4'b0000;
      req_b      = 4'b0000;
      resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Returns negedges waited until resp_valid, or -1 if the budget runs out.
   task automatic wait_resp(output int n);
      int i;
      n = -1;
      i = 0;
      while (n < 0 && i < 20) begin
         i++;
         @(negedge clk);
         #1;
         if (resp_valid === 1'b1) n = i;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 4'b0000; req_a = 4'b0000; req_b = 4'b0000; resp_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({resp_valid, resp_id, resp_z, xg_a, xg_b, req_ready} !== 10'b0) begin
         errors++;
         $display("FAIL reset_init: got valid=%b id=%0d z=%b xa=%b xb=%b ready=%b, need all 0",
                  resp_valid, resp_id, resp_z, xg_a, xg_b, req_ready);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_single;
      int n;
      apply_reset();
      req_valid = 4'b0100; req_a = 4'b0100; req_b = 4'b0000;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL single_ready: got %b, need 0100", req_ready);
      end
      @(posedge clk); #1; req_valid = 4'b0000;
      @(negedge clk); #1;
      checks++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL single_issue: ready=%b valid=%b, need 0000/0", req_ready, resp_valid);
      end
      wait_resp(n);
      n = n + 1;
      checks++;
      if (n !== 3) begin
         errors++; $display("FAIL single_latency: got %0d cycles, need 3", n);
      end
      checks++;
      if (resp_id !== 2'd2 || resp_z !== 1'b1) begin
         errors++; $display("FAIL single_resp: id=%0d z=%b, need id=2 z=1", resp_id, resp_z);
      end
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++; $display("FAIL single_drop: resp_valid=%b after handshake, need 0", resp_valid);
      end
   endtask

   task automatic test_reset_mid_wait;
      req_valid = 4'b1000; req_a = 4'b1000; req_b = 4'b0000;
      @(posedge clk); #1; req_valid = 4'b0000;
      @(posedge clk); #2;
      checks++;
      if (xg_a !== 1'b1 || resp_id !== 2'd3) begin
         errors++; $display("FAIL pre_reset: xg_a=%b id=%0d, need 1/3", xg_a, resp_id);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({resp_valid, resp_id, resp_z, xg_a, xg_b, req_ready} !== 10'b0) begin
         errors++;
         $display("FAIL reset_mid_wait: got valid=%b id=%0d z=%b xa=%b xb=%b ready=%b, need all 0",
                  resp_valid, resp_id, resp_z, xg_a, xg_b, req_ready);
      end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         checks++;
         if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_no_resp: resp_valid=%b at cycle %0d, need 0", resp_valid, c);
         end
      end
   endtask

   task automatic test_contention;
      int         n;
      logic [3:0] z_tab;
      logic [3:0] exp_ready;
`ifdef XOR_ARB_RR_EN
      int         order [5] = '{0, 1, 2, 3, 0};
      apply_reset();
      req_valid = 4'b1111; req_a = 4'b0101; req_b = 4'b0011;
      z_tab = 4'b0110;
`else
      int         order [5] = '{1, 1, 1, 1, 1};
      apply_reset();
      req_valid = 4'b1010; req_a = 4'b1010; req_b = 4'b1000;
      z_tab = 4'b0010;
`endif
      for (int t = 0; t < 5; t++) begin
         if (t > 0) @(negedge clk);
         #1;
         exp_ready = 4'b0001 << order[t];
         checks++;
         if (req_ready !== exp_ready) begin
            errors++; $display("FAIL contention_grant[%0d]: ready=%b, need %b", t, req_ready, exp_ready);
         end
         wait_resp(n);
         checks++;
         if (n < 0) begin
            errors++; $display("FAIL contention_timeout[%0d]: resp_valid=%b, need 1", t, resp_valid);
         end
         checks++;
         if (resp_id !== 2'(order[t]) || resp_z !== z_tab[order[t]]) begin
            errors++; $display("FAIL contention_resp[%0d]: id=%0d z=%b, need id=%0d z=%b",
                               t, resp_id, resp_z, order[t], z_tab[order[t]]);
         end
      end
      @(negedge clk); req_valid = 4'b0000;
   endtask

   task automatic test_backpressure;
      int n;
      apply_reset();
      resp_ready = 1'b0;
      req_valid = 4'b0010; req_a = 4'b1000; req_b = 4'b0010;
      @(posedge clk); #1; req_valid = 4'b1000;
      wait_resp(n);
      checks++;
      if (n < 0) begin
         errors++; $display("FAIL bp_timeout: resp_valid=%b, need 1", resp_valid);
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_z !== 1'b1 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_hold[%0d]: valid=%b id=%0d z=%b ready=%b, need 1/1/1/0000",
                               c, resp_valid, resp_id, resp_z, req_ready);
         end
         @(negedge clk); #1;
      end
      resp_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin
         errors++; $display("FAIL bp_release: valid=%b ready=%b, need 0/1000", resp_valid, req_ready);
      end
      @(posedge clk); #1; req_valid = 4'b0000;
      wait_resp(n);
      checks++;
      if (n < 0 || resp_id !== 2'd3 || resp_z !== 1'b1) begin
         errors++; $display("FAIL bp_next: waited=%0d id=%0d z=%b, need id=3 z=1", n, resp_id, resp_z);
      end
      @(negedge clk);
   endtask

   task automatic test_truth_table;
      int         n;
      logic [3:0] ta = 4'b1100;
      logic [3:0] tb = 4'b1010;
      logic [3:0] tz = 4'b0110;
      apply_reset();
      for (int v = 0; v < 4; v++) begin
         req_valid = 4'b0001; req_a = {3'b000, ta[3-v]}; req_b = {3'b000, tb[3-v]};
         #1;
         checks++;
         if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL tt_ready[%0d]: ready=%b, need 0001", v, req_ready);
         end
         @(posedge clk); #1; req_valid = 4'b0000;
         wait_resp(n);
         checks++;
         if (n < 0 || resp_id !== 2'd0 || resp_z !== tz[3-v]) begin
            errors++; $display("FAIL tt_resp[%0d]: a=%b b=%b z=%b id=%0d, need z=%b id=0",
                               v, ta[3-v], tb[3-v], resp_z, resp_id, tz[3-v]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_reset_mid_wait();
      test_contention();
      test_backpressure();
      test_truth_table();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1);
   end

endmodule
